// File: rtl/cl_note_stream_controller.sv
// Note stream controller: per-channel timestamp lists held in one shared
// memory, filled at runtime by the song-data loader and streamed to the
// note-lane renderers. Service is round-robin, one word per grant, once song
// time passes the start point.
module cl_note_stream_controller #(
    parameter int NUM_CH     = 37,
    parameter int DATA_W     = 16,
    parameter int DEPTH_W    = 4,
    parameter int CH_W       = 6,
    parameter int START_TIME = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              song_time,
    input  logic                     write_en,
    input  logic [31:0]              write_word,
    input  logic [NUM_CH-1:0]        metadata_request,
    output logic [NUM_CH-1:0]        metadata_available,
    output logic [NUM_CH*DATA_W-1:0] metadata_link,
    output logic [NUM_CH-1:0]        metadata_exhausted,
    output logic                     loaded,
    output logic                     load_error
);

    localparam int DEPTH  = 1 << DEPTH_W;
    localparam int ADDR_W = CH_W + DEPTH_W;
    localparam int MEM_D  = NUM_CH * DEPTH;

    localparam logic [2:0] CMD_NOTE = 3'b000;
    localparam logic [2:0] CMD_END  = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t              state;
    logic                running;
    logic [CH_W-1:0]     last_served;
    logic [DEPTH_W:0]    wr_cnt [NUM_CH];
    logic [DEPTH_W:0]    rd_ptr [NUM_CH];

    // Read request registered at grant, data returned one cycle later.
    logic [ADDR_W-1:0]   rd_addr_p0;
    logic [CH_W-1:0]     rd_ch_p0;
    logic [DATA_W-1:0]   rd_data_p1;

    logic [DATA_W-1:0]   mem [MEM_D];

    // Loader word fields. Channel c, entry i lives at {c, i}.
    logic [2:0]          wr_cmd;
    logic [CH_W-1:0]     wr_ch;
    logic [DATA_W-1:0]   wr_ts;
    logic                wr_ch_ok;
    logic                wr_full;
    logic                mem_we;
    logic [ADDR_W-1:0]   wr_addr;

    assign wr_cmd   = write_word[31:29];
    assign wr_ch    = write_word[23 +: CH_W];
    assign wr_ts    = write_word[DATA_W-1:0];
    assign wr_ch_ok = (int'(wr_ch) < NUM_CH);
    assign wr_full  = wr_ch_ok ? wr_cnt[wr_ch][DEPTH_W] : 1'b1;
    assign mem_we   = write_en && !loaded && (wr_cmd == CMD_NOTE) && wr_ch_ok && !wr_full;
    assign wr_addr  = {wr_ch, wr_cnt[wr_ch][DEPTH_W-1:0]};

    // Round-robin pick: first requesting, non-exhausted channel after last_served.
    // The pulse register always clears on the edge that ends its cycle, so a
    // channel still showing its pulse is treated as free; this keeps repeated
    // service of a lone requester at one word every three cycles.
    logic                pick_found;
    logic [CH_W-1:0]     pick_ch;
    int                  idx;
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        idx        = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(last_served) + 1 + i) % NUM_CH;
            if (!pick_found && metadata_request[idx] && !metadata_exhausted[idx]) begin
                pick_found = 1'b1;
                pick_ch    = CH_W'(idx);
            end
        end
    end

    // Shared timestamp memory: loader writes, synchronous one-cycle read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_ts;
        end
        rd_data_p1 <= mem[rd_addr_p0];
    end

    // Load bookkeeping, start gate and the IDLE -> READ -> PRESENT serve FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            running            <= 1'b0;
            last_served        <= CH_W'(NUM_CH - 1);
            metadata_available <= '0;
            metadata_link      <= '0;
            metadata_exhausted <= '0;
            loaded             <= 1'b0;
            load_error         <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_cnt[c] <= '0;
                rd_ptr[c] <= '0;
            end
        end else begin
            metadata_available <= '0;

            if (write_en && !loaded) begin
                if (wr_cmd == CMD_NOTE) begin
                    if (wr_ch_ok && !wr_full) begin
                        wr_cnt[wr_ch] <= wr_cnt[wr_ch] + 1'b1;
                    end else begin
                        load_error <= 1'b1;
                    end
                end else if (wr_cmd == CMD_END) begin
                    loaded <= 1'b1;
                end else begin
                    load_error <= 1'b1;
                end
            end

            if (loaded && (song_time > 16'(START_TIME))) begin
                running <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (running && pick_found) begin
                        if (rd_ptr[pick_ch] == wr_cnt[pick_ch]) begin
                            metadata_exhausted[pick_ch] <= 1'b1;
                        end else begin
                            rd_addr_p0 <= {pick_ch, rd_ptr[pick_ch][DEPTH_W-1:0]};
                            rd_ch_p0   <= pick_ch;
                            state      <= READ;
                        end
                    end
                end
                READ: begin
                    state <= PRESENT;
                end
                PRESENT: begin
                    metadata_link[int'(rd_ch_p0)*DATA_W +: DATA_W] <= rd_data_p1;
                    metadata_available[rd_ch_p0] <= 1'b1;
                    rd_ptr[rd_ch_p0]             <= rd_ptr[rd_ch_p0] + 1'b1;
                    last_served                  <= rd_ch_p0;
                    state                        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cl_note_stream_controller.sv
// Directed bench for cl_note_stream_controller: loading, start gate,
// round-robin order, overflow, bad loader words and reset abort.
module tb_cl_note_stream_controller;

    localparam int NUM_CH = 37;
    localparam int DATA_W = 16;

    logic                     clk;
    logic                     reset;
    logic [15:0]              song_time;
    logic                     write_en;
    logic [31:0]              write_word;
    logic [NUM_CH-1:0]        metadata_request;
    logic [NUM_CH-1:0]        metadata_available;
    logic [NUM_CH*DATA_W-1:0] metadata_link;
    logic [NUM_CH-1:0]        metadata_exhausted;
    logic                     loaded;
    logic                     load_error;

    int checks;
    int fails;

    cl_note_stream_controller #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH_W(4), .CH_W(6), .START_TIME(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .song_time(song_time),
        .write_en(write_en),
        .write_word(write_word),
        .metadata_request(metadata_request),
        .metadata_available(metadata_available),
        .metadata_link(metadata_link),
        .metadata_exhausted(metadata_exhausted),
        .loaded(loaded),
        .load_error(load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] slice(input int ch);
        return metadata_link[ch*DATA_W +: DATA_W];
    endfunction

    // All stimulus changes at 1 ns after a rising edge.
    task automatic do_reset();
        reset            = 1'b1;
        write_en         = 1'b0;
        write_word       = '0;
        metadata_request = '0;
        song_time        = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic put_word(input logic [2:0] cmd, input int ch, input logic [15:0] ts);
        logic [5:0] c6;
        c6         = 6'(ch);
        write_word = {cmd, c6, 7'b0, ts};
        write_en   = 1'b1;
        @(posedge clk);
        #1;
        write_en   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (metadata_available !== '0) begin fails++; $display("FAIL reset_avail got %h want 0", metadata_available); end
        checks++; if (metadata_link !== '0) begin fails++; $display("FAIL reset_link got %h want 0", metadata_link); end
        checks++; if (metadata_exhausted !== '0) begin fails++; $display("FAIL reset_exh got %h want 0", metadata_exhausted); end
        checks++; if (loaded !== 1'b0) begin fails++; $display("FAIL reset_loaded got %b want 0", loaded); end
        checks++; if (load_error !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", load_error); end
    endtask

    task automatic test_single_channel();
        int n;
        int pc [3];
        logic [15:0] pv [3];
        int other;
        logic [NUM_CH-1:0] m;
        n = 0; other = 0;
        for (int k = 0; k < 3; k++) begin pc[k] = 0; pv[k] = '0; end
        m = '0; m[24] = 1'b1;
        do_reset();
        put_word(3'b000, 24, 16'd400);
        put_word(3'b000, 24, 16'd2000);
        put_word(3'b000, 24, 16'd3000);
        put_word(3'b111, 0, 16'd0);
        checks++; if (loaded !== 1'b1) begin fails++; $display("FAIL single_loaded got %b want 1", loaded); end
        song_time = 16'd6;
        metadata_request[24] = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (metadata_available[24]) begin
                if (n < 3) begin pc[n] = cyc; pv[n] = slice(24); end
                n++;
            end
            if ((metadata_available & ~m) != '0) other++;
        end
        checks++; if (n !== 3) begin fails++; $display("FAIL single_pulses got %0d want 3", n); end
        checks++; if (pv[0] !== 16'd400) begin fails++; $display("FAIL single_w0 got %0d want 400", pv[0]); end
        checks++; if (pv[1] !== 16'd2000) begin fails++; $display("FAIL single_w1 got %0d want 2000", pv[1]); end
        checks++; if (pv[2] !== 16'd3000) begin fails++; $display("FAIL single_w2 got %0d want 3000", pv[2]); end
        checks++; if (pc[1] - pc[0] !== 3) begin fails++; $display("FAIL single_gap01 got %0d want 3", pc[1] - pc[0]); end
        checks++; if (pc[2] - pc[1] !== 3) begin fails++; $display("FAIL single_gap12 got %0d want 3", pc[2] - pc[1]); end
        checks++; if (metadata_exhausted !== m) begin fails++; $display("FAIL single_exh got %h want %h", metadata_exhausted, m); end
        checks++; if (slice(24) !== 16'd3000) begin fails++; $display("FAIL single_hold got %0d want 3000", slice(24)); end
        checks++; if (other !== 0) begin fails++; $display("FAIL single_other got %0d want 0", other); end
    endtask

    task automatic test_start_gate();
        int n;
        int pc [2];
        logic [15:0] pv [2];
        n = 0;
        for (int k = 0; k < 2; k++) begin pc[k] = 0; pv[k] = '0; end
        do_reset();
        put_word(3'b000, 26, 16'd1234);
        put_word(3'b000, 26, 16'd4321);
        put_word(3'b111, 0, 16'd0);
        song_time = 16'd5;
        metadata_request[26] = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (metadata_available != '0) n++;
        end
        checks++; if (n !== 0) begin fails++; $display("FAIL gate_early got %0d pulses want 0", n); end
        n = 0;
        song_time = 16'd6;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (metadata_available[26]) begin
                if (n < 2) begin pc[n] = cyc; pv[n] = slice(26); end
                n++;
                song_time = 16'd3;
            end
        end
        checks++; if (pc[0] !== 4) begin fails++; $display("FAIL gate_latency got %0d want 4", pc[0]); end
        checks++; if (pv[0] !== 16'd1234) begin fails++; $display("FAIL gate_w0 got %0d want 1234", pv[0]); end
        checks++; if (pc[1] !== 7) begin fails++; $display("FAIL gate_second got %0d want 7", pc[1]); end
        checks++; if (pv[1] !== 16'd4321) begin fails++; $display("FAIL gate_w1 got %0d want 4321", pv[1]); end
        checks++; if (n !== 2) begin fails++; $display("FAIL gate_pulses got %0d want 2", n); end
    endtask

    task automatic test_round_robin();
        int chs [4];
        logic [15:0] vals [4];
        int ord [8];
        logic [15:0] ov [8];
        int n;
        logic [NUM_CH-1:0] m;
        chs[0] = 24; chs[1] = 26; chs[2] = 28; chs[3] = 31;
        vals[0] = 16'd11; vals[1] = 16'd22; vals[2] = 16'd33; vals[3] = 16'd44;
        for (int k = 0; k < 8; k++) begin ord[k] = -1; ov[k] = '0; end
        n = 0;
        m = '0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            put_word(3'b000, chs[k], vals[k]);
            m[chs[k]] = 1'b1;
        end
        put_word(3'b111, 0, 16'd0);
        put_word(3'b000, 24, 16'd99);
        song_time = 16'd6;
        repeat (3) tick();
        metadata_request = m;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            for (int c = 0; c < NUM_CH; c++) begin
                if (metadata_available[c]) begin
                    if (n < 8) begin ord[n] = c; ov[n] = slice(c); end
                    n++;
                end
            end
        end
        checks++; if (n !== 4) begin fails++; $display("FAIL rr_pulses got %0d want 4", n); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (ord[k] !== chs[k]) begin fails++; $display("FAIL rr_order%0d got %0d want %0d", k, ord[k], chs[k]); end
            checks++; if (ov[k] !== vals[k]) begin fails++; $display("FAIL rr_value%0d got %0d want %0d", k, ov[k], vals[k]); end
        end
        checks++; if (metadata_exhausted !== m) begin fails++; $display("FAIL rr_exh got %h want %h", metadata_exhausted, m); end
        checks++; if (load_error !== 1'b0) begin fails++; $display("FAIL rr_err got %b want 0", load_error); end
    endtask

    task automatic test_overflow();
        int n;
        int vbad;
        do_reset();
        for (int k = 0; k < 16; k++) put_word(3'b000, 2, 16'(100 + k));
        checks++; if (load_error !== 1'b0) begin fails++; $display("FAIL ovf_err16 got %b want 0", load_error); end
        put_word(3'b000, 2, 16'd999);
        checks++; if (load_error !== 1'b1) begin fails++; $display("FAIL ovf_err17 got %b want 1", load_error); end
        put_word(3'b111, 0, 16'd0);
        song_time = 16'd6;
        metadata_request[2] = 1'b1;
        n = 0; vbad = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            tick();
            if (metadata_available[2]) begin
                if (slice(2) !== 16'(100 + n)) vbad++;
                n++;
            end
        end
        checks++; if (n !== 16) begin fails++; $display("FAIL ovf_pulses got %0d want 16", n); end
        checks++; if (vbad !== 0) begin fails++; $display("FAIL ovf_values got %0d wrong want 0", vbad); end
        checks++; if (metadata_exhausted[2] !== 1'b1) begin fails++; $display("FAIL ovf_exh got %b want 1", metadata_exhausted[2]); end
    endtask

    task automatic test_bad_words();
        int n;
        do_reset();
        put_word(3'b000, 40, 16'd77);
        checks++; if (load_error !== 1'b1) begin fails++; $display("FAIL bad_chan_err got %b want 1", load_error); end
        do_reset();
        checks++; if (load_error !== 1'b0) begin fails++; $display("FAIL bad_clear_err got %b want 0", load_error); end
        put_word(3'b010, 5, 16'd88);
        checks++; if (load_error !== 1'b1) begin fails++; $display("FAIL bad_cmd_err got %b want 1", load_error); end
        put_word(3'b111, 0, 16'd0);
        song_time = 16'd6;
        metadata_request = '1;
        n = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            tick();
            if (metadata_available != '0) n++;
        end
        checks++; if (n !== 0) begin fails++; $display("FAIL bad_pulses got %0d want 0", n); end
        checks++; if (metadata_exhausted !== {NUM_CH{1'b1}}) begin fails++; $display("FAIL bad_exh got %h want all ones", metadata_exhausted); end
    endtask

    task automatic test_reset_in_read();
        int n;
        do_reset();
        put_word(3'b000, 24, 16'd555);
        put_word(3'b111, 0, 16'd0);
        song_time = 16'd6;
        repeat (3) tick();
        metadata_request[24] = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (metadata_available !== '0) begin fails++; $display("FAIL rir_avail got %h want 0", metadata_available); end
        checks++; if (metadata_link !== '0) begin fails++; $display("FAIL rir_link got %h want 0", metadata_link); end
        checks++; if (loaded !== 1'b0) begin fails++; $display("FAIL rir_loaded got %b want 0", loaded); end
        checks++; if (metadata_exhausted !== '0) begin fails++; $display("FAIL rir_exh got %h want 0", metadata_exhausted); end
        reset = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (metadata_available != '0) n++;
        end
        checks++; if (n !== 0) begin fails++; $display("FAIL rir_pulse got %0d want 0", n); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_single_channel();
        test_start_gate();
        test_round_robin();
        test_overflow();
        test_bad_words();
        test_reset_in_read();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
